mipi_packet_framer: RTL
=======================

Name: mipi_packet_framer

Overview:
- Transmit-side framer: takes one parallel payload frame of DLEN bytes plus descriptor fields and serialises it into the 48-bit MIPI word stream our MIPI receive verifier parses.
- Word order per frame: header (SOF + packet id), descriptor (dtype, dlen, phl_id), ceil(DLEN/6) data words with 24-bit halves swapped, one guard word.
- Sits between the miner job/result logic and the MIPI TX pixel interface.

Parameters:
- DLEN, 6, payload length in bytes; must be ≥1; WORDS = ceil(DLEN/6).
- SOF, 24'hEAFF99, start-of-frame marker placed in header word bits [47:24].
- GAP, 2, idle cycles forced between guard word and next frame accept (0 allowed).

Ports:
- tx_pixel_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- frame_valid  in  1  upstream offers a frame.
- frame_ready  out  1  framer can accept; high only in IDLE.
- frame_payload  in  DLEN*8  payload; byte 0 = bits [DLEN*8-1 -: 8] (MSB first).
- frame_dtype  in  8  data type field.
- frame_phl_id  in  8  physical-lane/channel id field.
- tx_ready  in  1  MIPI TX accepts the current word this cycle.
- tx_packet  out  48  word on the wire.
- tx_valid  out  1  tx_packet is a frame word.
- frame_done  out  1  one-cycle pulse when the guard word is accepted.
- pkt_id  out  24  id to be used for the next frame.

Behaviour:
- Reset (sync, priority over everything, including mid-frame): state=IDLE, tx_packet=0, tx_valid=0, frame_ready=0 for the reset cycle then 1, frame_done=0, pkt_id=0, gap counter=0. A partly sent frame is abandoned, with no guard word.
- Accept: frame_valid & frame_ready on a clock edge. The framer registers payload, dtype and phl_id, then goes to HDR. Inputs are ignored outside accept.
- Output is registered. The header word is on tx_packet the cycle after accept.
- Advance rule: a word moves on only when tx_valid & tx_ready. With tx_ready low, tx_packet and tx_valid hold steady.
- States:
  - IDLE: tx_valid=0, tx_packet=0.
  - HDR: word = {SOF, pkt_id}.
  - DESC: word = {dtype, 32-bit dlen = DLEN, phl_id}.
  - DATA: WORDS words. Chunk i = padded payload bits [WORDS*48-1-48*i -: 48]; the payload is zero-padded in the LSBs to WORDS*48. Word = {chunk[23:0], chunk[47:24]}. A 0..WORDS-1 word counter runs here.
  - GUARD: word = 48'h0, or the checksum word when the option is built in.
  - GAP: tx_valid=0 for GAP cycles, then IDLE. With GAP=0, go GUARD→IDLE directly.
- On guard acceptance: frame_done pulses for 1 cycle and pkt_id increments by 1, wrapping 24'hFFFFFF→0.
- Idle/gap output is always 48'h0, so it can never match SOF in [47:24].
- Minimum frame length at tx_ready=1: 3+WORDS cycles of tx_valid, then GAP idle cycles, then 1 IDLE cycle before the next accept.
- frame_ready is combinational on state (IDLE & ~rst).

Optional Feature:
- Macro: MIPI_FRAMER_CRC16_EN.
- Defined:
  - GUARD word = {32'h0, crc16}.
  - crc16 is CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, no reflect, no xorout) over the DLEN payload bytes in byte order. Pad bytes are excluded.
  - The CRC is computed in the cycles between accept and GUARD, and is ready before GUARD regardless of tx_ready.
- Not defined: GUARD word = 48'h0 and no CRC logic is built.

Test Plan:
- Basic frame (DLEN=6, tx_ready=1): accept payload 48'h112233445566, dtype 8'h2A, phl_id 8'h05 → words EAFF99_000000, 2A_00000006_05, 445566_112233, 000000000000. tx_valid is high for exactly 4 cycles, frame_done pulses with the guard word, pkt_id becomes 1.
- Padding (DLEN=9, payload "123456789" = 72'h313233343536373839) → dlen field 0x00000009, data words 343536_313233 and 000000_373839. With MIPI_FRAMER_CRC16_EN the guard is 48'h0000000029B1.
- Backpressure: drop tx_ready for 3 cycles during DESC and for 1 cycle on the last DATA word → words held unchanged, no word skipped or duplicated, total tx_valid cycles = 4+4.
- Back-to-back frames with GAP=2 and frame_valid held high → second accept exactly 3 cycles after guard acceptance, second header carries pkt_id 1.
- Reset mid-DATA → next cycle tx_valid=0, tx_packet=0, pkt_id=0. A fresh frame then starts with header pkt_id 0.
- pkt_id wrap: preload by sending frames until pkt_id=24'hFFFFFF (or force) → that frame's header ends in FFFFFF, next header ends in 000000.

Source files
------------

// File: rtl/mipi_packet_framer.sv
// Serialises one DLEN-byte payload frame into 48-bit MIPI words: header, descriptor, data, guard.
// Build with MIPI_FRAMER_CRC16_EN to carry a CRC-16/CCITT-FALSE of the payload in the guard word.
module mipi_packet_framer #(
    parameter int          DLEN = 6,
    parameter logic [23:0] SOF  = 24'hEAFF99,
    parameter int          GAP  = 2
) (
    input  logic              tx_pixel_clk,
    input  logic              rst,
    input  logic              frame_valid,
    output logic              frame_ready,
    input  logic [DLEN*8-1:0] frame_payload,
    input  logic [7:0]        frame_dtype,
    input  logic [7:0]        frame_phl_id,
    input  logic              tx_ready,
    output logic [47:0]       tx_packet,
    output logic              tx_valid,
    output logic              frame_done,
    output logic [23:0]       pkt_id
);
    localparam int WORDS = (DLEN + 5) / 6;
    localparam int PADW  = WORDS * 48;
    localparam int PADB  = PADW - DLEN * 8;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DESC, S_DATA, S_GUARD, S_GAP} state_t;

    state_t          state;
    logic [PADW-1:0] pay_q;
    logic [7:0]      dtype_q;
    logic [7:0]      phl_q;
    logic [CW-1:0]   dat_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [47:0]     guard_word;
    logic            tx_fire;

    // Chunk idx of the zero-padded payload, with its 24-bit halves swapped onto the wire.
    function automatic logic [47:0] data_word(input logic [PADW-1:0] p, input logic [CW-1:0] idx);
        logic [PADW-1:0] t;
        t = p << (48 * int'(idx));
        return {t[PADW-25 -: 24], t[PADW-1 -: 24]};
    endfunction

    assign tx_fire     = tx_valid & tx_ready;
    assign frame_ready = (state == S_IDLE) & ~rst;
    assign frame_done  = tx_fire & (state == S_GUARD) & ~rst;

`ifdef MIPI_FRAMER_CRC16_EN
    logic [15:0]   crc_q;
    logic [CW-1:0] crc_idx;
    logic          crc_busy;

    function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in ^ {b, 8'h00};
        for (int i = 0; i < 8; i++)
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    // Six bytes per cycle, pad bytes skipped; finishes WORDS cycles after accept,
    // which is always before the guard word can be loaded.
    function automatic logic [15:0] crc_chunk(input logic [15:0] c_in, input logic [PADW-1:0] p,
                                              input logic [CW-1:0] idx);
        logic [15:0]     c;
        logic [PADW-1:0] t;
        c = c_in;
        t = p << (48 * int'(idx));
        for (int k = 0; k < 6; k++) begin
            if (int'(idx) * 6 + k < DLEN)
                c = crc_byte(c, t[PADW-1 -: 8]);
            t = t << 8;
        end
        return c;
    endfunction

    always_ff @(posedge tx_pixel_clk) begin
        if (rst) begin
            crc_q    <= 16'hFFFF;
            crc_idx  <= '0;
            crc_busy <= 1'b0;
        end else if (frame_valid && frame_ready) begin
            crc_q    <= 16'hFFFF;
            crc_idx  <= '0;
            crc_busy <= 1'b1;
        end else if (crc_busy) begin
            crc_q <= crc_chunk(crc_q, pay_q, crc_idx);
            if (crc_idx == CW'(WORDS - 1))
                crc_busy <= 1'b0;
            else
                crc_idx <= crc_idx + CW'(1);
        end
    end

    assign guard_word = {32'h0, crc_q};
`else
    assign guard_word = 48'h0;
`endif

    always_ff @(posedge tx_pixel_clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tx_packet <= 48'h0;
            tx_valid  <= 1'b0;
            pkt_id    <= 24'h0;
            gap_cnt   <= '0;
            dat_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_valid) begin
                        pay_q     <= PADW'(frame_payload) << PADB;
                        dtype_q   <= frame_dtype;
                        phl_q     <= frame_phl_id;
                        tx_packet <= {SOF, pkt_id};
                        tx_valid  <= 1'b1;
                        state     <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (tx_fire) begin
                        tx_packet <= {dtype_q, 32'(DLEN), phl_q};
                        state     <= S_DESC;
                    end
                end
                S_DESC: begin
                    if (tx_fire) begin
                        tx_packet <= data_word(pay_q, '0);
                        dat_cnt   <= '0;
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tx_fire) begin
                        if (dat_cnt == CW'(WORDS - 1)) begin
                            tx_packet <= guard_word;
                            state     <= S_GUARD;
                        end else begin
                            tx_packet <= data_word(pay_q, dat_cnt + CW'(1));
                            dat_cnt   <= dat_cnt + CW'(1);
                        end
                    end
                end
                S_GUARD: begin
                    if (tx_fire) begin
                        tx_packet <= 48'h0;
                        tx_valid  <= 1'b0;
                        pkt_id    <= pkt_id + 24'd1;
                        gap_cnt   <= '0;
                        state     <= (GAP == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GW'(GAP - 1))
                        state <= S_IDLE;
                    else
                        gap_cnt <= gap_cnt + GW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
